sdi_xcvr_pll_reset_sequencer: RTL and testbench

SDI_XCVR_PLL_RESET_SEQUENCER -- requirements
Module: sdi_xcvr_pll_reset_sequencer

---
 rtl/sdi_xcvr_pll_reset_sequencer.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_sdi_xcvr_pll_reset_sequencer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sdi_xcvr_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------------------------
// sdi_xcvr_pll_reset_sequencer
//
// Brings an SDI transceiver TX path out of reset. The sequence is:
//   1. Hold the TX PLL in powerdown.
//   2. Wait for PLL lock.
//   3. Qualify the lock over a number of consecutive cycles.
//   4. Release the master clock-generation block (MCGB).
//   5. Release the TX analog reset.
//   6. Release the TX digital reset.
//   7. Report ready.
// Losing lock after qualification, or a powerdown request, restarts the sequence.
//
// Parameters (all minimum 1, except LOCK_TIMEOUT which is minimum 2):
//   PD_CYCLES    cycles pll_powerdown_o is held per powerdown pass
//   LOCK_TIMEOUT WAIT_LOCK cycles without lock before a timeout/retry
//   LOCK_STABLE  consecutive locked cycles before lock is qualified
//   MCGB_CYCLES  cycles mcgb_rst_o is held after lock qualifies
//   TXA_CYCLES   cycles tx_analog_reset_o is held after MCGB release
//   TXD_CYCLES   cycles tx_digital_reset_o is held after analog release
//
// Ports:
//   clock_i              single clock for all logic
//   reset_i              synchronous, active-high reset
//   pll_locked_i         raw TX PLL lock indicator
//   pll_powerdown_req_i  level request forcing PLL powerdown
//   pll_powerdown_o      PLL powerdown drive
//   mcgb_rst_o           master clock-generation-block reset
//   tx_analog_reset_o    TX analog reset
//   tx_digital_reset_o   TX digital reset
//   tx_ready_o           sequence complete, TX usable
//   pll_locked_output_o  qualified lock status
//   lock_timeout_o       sticky; set on any WAIT_LOCK timeout
//   retry_count_o        saturating count of lock timeouts
//   lock_loss_count_o    saturating count of lock losses after qualification
//   state_o              PD=0, WAIT_LOCK=1, STABLE=2, MCGB=3, TXA=4, TXD=5, READY=6
//
// Optional feature:
//   SDI_PLL_SEQ_LOCK_SYNC_EN
//     Defined: pll_locked_i passes through a two-flop synchronizer. This adds two cycles of
//     latency to every lock reaction.
//     Undefined: pll_locked_i is used directly and must be synchronous to clock_i.
// ---------------------------------------------------------------------------------------------

module sdi_xcvr_pll_reset_sequencer #(
    parameter int unsigned PD_CYCLES    = 100,
    parameter int unsigned LOCK_TIMEOUT = 100000,
    parameter int unsigned LOCK_STABLE  = 64,
    parameter int unsigned MCGB_CYCLES  = 32,
    parameter int unsigned TXA_CYCLES   = 32,
    parameter int unsigned TXD_CYCLES   = 16
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       pll_locked_i,
    input  logic       pll_powerdown_req_i,
    output logic       pll_powerdown_o,
    output logic       mcgb_rst_o,
    output logic       tx_analog_reset_o,
    output logic       tx_digital_reset_o,
    output logic       tx_ready_o,
    output logic       pll_locked_output_o,
    output logic       lock_timeout_o,
    output logic [3:0] retry_count_o,
    output logic [3:0] lock_loss_count_o,
    output logic [2:0] state_o
);

    // -----------------------------------------------------------------------------------------
    // Dwell counter sizing: the counter only ever reaches (dwell - 1), so $clog2 of the largest
    // dwell is enough and no dwell can wrap.
    // -----------------------------------------------------------------------------------------
    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MaxDwell = max_u(max_u(max_u(PD_CYCLES, LOCK_TIMEOUT),
                                                   max_u(LOCK_STABLE, MCGB_CYCLES)),
                                             max_u(TXA_CYCLES, TXD_CYCLES));
    localparam int unsigned CntW     = (MaxDwell > 1) ? $clog2(MaxDwell) : 1;

    localparam logic [CntW-1:0] PdLast   = CntW'(PD_CYCLES - 1);
    localparam logic [CntW-1:0] ToLast   = CntW'(LOCK_TIMEOUT - 1);
    localparam logic [CntW-1:0] StbLast  = CntW'(LOCK_STABLE - 1);
    localparam logic [CntW-1:0] McgbLast = CntW'(MCGB_CYCLES - 1);
    localparam logic [CntW-1:0] TxaLast  = CntW'(TXA_CYCLES - 1);
    localparam logic [CntW-1:0] TxdLast  = CntW'(TXD_CYCLES - 1);

    // Elaboration-time parameter sanity.
    if (PD_CYCLES < 1 || LOCK_STABLE < 1 || MCGB_CYCLES < 1 ||
        TXA_CYCLES < 1 || TXD_CYCLES < 1) begin : gen_bad_dwell
        $error("sdi_xcvr_pll_reset_sequencer: dwell parameters must be at least 1");
    end
    if (LOCK_TIMEOUT < 2) begin : gen_bad_timeout
        $error("sdi_xcvr_pll_reset_sequencer: LOCK_TIMEOUT must be at least 2");
    end

    typedef enum logic [2:0] {
        StPd       = 3'd0,
        StWaitLock = 3'd1,
        StStable   = 3'd2,
        StMcgb     = 3'd3,
        StTxa      = 3'd4,
        StTxd      = 3'd5,
        StReady    = 3'd6
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
    logic [3:0]      retry_q, retry_d;
    logic [3:0]      loss_q, loss_d;
    logic            lk;
    logic            lock_lost;

    // -----------------------------------------------------------------------------------------
    // Lock source
    // -----------------------------------------------------------------------------------------
`ifdef SDI_PLL_SEQ_LOCK_SYNC_EN
    logic sync1_q, sync2_q;

    // The synchronizer is flushed while the PLL is powered down. A lock level captured before or
    // during powerdown is stale, so WAIT_LOCK only ever sees lock sampled after release.
    always_ff @(posedge clock_i) begin
        if (reset_i || state_q == StPd) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= pll_locked_i;
            sync2_q <= sync1_q;
        end
    end

    assign lk = sync2_q;
`else
    assign lk = pll_locked_i;
`endif

    // -----------------------------------------------------------------------------------------
    // State and counter registers
    // -----------------------------------------------------------------------------------------
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= StPd;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
            retry_q   <= 4'd0;
            loss_q    <= 4'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
            retry_q   <= retry_d;
            loss_q    <= loss_d;
        end
    end

    // Lock loss only counts once lock has been qualified (MCGB onwards).
    assign lock_lost = !lk && (state_q == StMcgb || state_q == StTxa ||
                               state_q == StTxd  || state_q == StReady);

    // -----------------------------------------------------------------------------------------
    // Next-state logic.
    // Priority: powerdown request > lock loss / timeout > dwell expiry.
    // Every transition clears the dwell counter.
    // -----------------------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        timeout_d = timeout_q;
        retry_d   = retry_q;
        loss_d    = loss_q;

        if (pll_powerdown_req_i) begin
            // Dwell is held at 0 so the full powerdown pass starts once the request drops.
            state_d = StPd;
            cnt_d   = '0;
        end else if (lock_lost) begin
            state_d = StPd;
            cnt_d   = '0;
            loss_d  = (loss_q == 4'hF) ? loss_q : loss_q + 4'd1;
        end else begin
            unique case (state_q)
                StPd: begin
                    if (cnt_q == PdLast) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end
                end
                StWaitLock: begin
                    if (lk) begin
                        state_d = StStable;
                        cnt_d   = '0;
                    end else if (cnt_q == ToLast) begin
                        state_d   = StPd;
                        cnt_d     = '0;
                        timeout_d = 1'b1;
                        retry_d   = (retry_q == 4'hF) ? retry_q : retry_q + 4'd1;
                    end
                end
                StStable: begin
                    // Any unlocked cycle restarts both the qualification and the timeout.
                    if (!lk) begin
                        state_d = StWaitLock;
                        cnt_d   = '0;
                    end else if (cnt_q == StbLast) begin
                        state_d = StMcgb;
                        cnt_d   = '0;
                    end
                end
                StMcgb: begin
                    if (cnt_q == McgbLast) begin
                        state_d = StTxa;
                        cnt_d   = '0;
                    end
                end
                StTxa: begin
                    if (cnt_q == TxaLast) begin
                        state_d = StTxd;
                        cnt_d   = '0;
                    end
                end
                StTxd: begin
                    if (cnt_q == TxdLast) begin
                        state_d = StReady;
                        cnt_d   = '0;
                    end
                end
                StReady: begin
                    // No dwell in READY; park the counter so it never wraps.
                    cnt_d = cnt_q;
                end
                default: begin
                    state_d = StPd;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------------------------
    // Moore output decode
    // -----------------------------------------------------------------------------------------
    always_comb begin
        pll_powerdown_o     = 1'b1;
        mcgb_rst_o          = 1'b1;
        tx_analog_reset_o   = 1'b1;
        tx_digital_reset_o  = 1'b1;
        tx_ready_o          = 1'b0;
        pll_locked_output_o = 1'b0;

        unique case (state_q)
            StPd: begin
            end
            StWaitLock, StStable: begin
                pll_powerdown_o = 1'b0;
            end
            StMcgb: begin
                pll_powerdown_o     = 1'b0;
                pll_locked_output_o = 1'b1;
            end
            StTxa: begin
                pll_powerdown_o     = 1'b0;
                mcgb_rst_o          = 1'b0;
                pll_locked_output_o = 1'b1;
            end
            StTxd: begin
                pll_powerdown_o     = 1'b0;
                mcgb_rst_o          = 1'b0;
                tx_analog_reset_o   = 1'b0;
                pll_locked_output_o = 1'b1;
            end
            StReady: begin
                pll_powerdown_o     = 1'b0;
                mcgb_rst_o          = 1'b0;
                tx_analog_reset_o   = 1'b0;
                tx_digital_reset_o  = 1'b0;
                tx_ready_o          = 1'b1;
                pll_locked_output_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign lock_timeout_o    = timeout_q;
    assign retry_count_o     = retry_q;
    assign lock_loss_count_o = loss_q;
    assign state_o           = state_q;

endmodule

// File: tb/tb_sdi_xcvr_pll_reset_sequencer.sv
// ---------------------------------------------------------------------------------------------
// tb_sdi_xcvr_pll_reset_sequencer
//
// Self-checking bench for the TX PLL reset sequencer.
// - A behavioural model uses a dwell table and an output table indexed by state number.
// - The DUT is compared against the model on every falling edge.
// - Directed scenarios add literal expectations at known cycle numbers.
// ---------------------------------------------------------------------------------------------

module tb_sdi_xcvr_pll_reset_sequencer;

    localparam int unsigned PD = 4;
    localparam int unsigned TO = 20;
    localparam int unsigned ST = 3;
    localparam int unsigned MC = 2;
    localparam int unsigned TA = 2;
    localparam int unsigned TD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lk_in = 1'b1;
    logic       req = 1'b0;
    logic       pd_o, mcgb_o, txa_o, txd_o, rdy_o, plo_o, to_o;
    logic [3:0] retry_o, loss_o;
    logic [2:0] state_o;

    always #5 clk = ~clk;

    sdi_xcvr_pll_reset_sequencer #(
        .PD_CYCLES    (PD),
        .LOCK_TIMEOUT (TO),
        .LOCK_STABLE  (ST),
        .MCGB_CYCLES  (MC),
        .TXA_CYCLES   (TA),
        .TXD_CYCLES   (TD)
    ) dut (
        .clock_i             (clk),
        .reset_i             (rst),
        .pll_locked_i        (lk_in),
        .pll_powerdown_req_i (req),
        .pll_powerdown_o     (pd_o),
        .mcgb_rst_o          (mcgb_o),
        .tx_analog_reset_o   (txa_o),
        .tx_digital_reset_o  (txd_o),
        .tx_ready_o          (rdy_o),
        .pll_locked_output_o (plo_o),
        .lock_timeout_o      (to_o),
        .retry_count_o       (retry_o),
        .lock_loss_count_o   (loss_o),
        .state_o             (state_o)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- behavioural model ----------------
    // States by number: 0 PD, 1 WAIT_LOCK, 2 STABLE, 3 MCGB, 4 TXA, 5 TXD, 6 READY.
    int  m_st = 0;
    int  m_age = 0;
    bit  m_to = 0;
    int  m_retry = 0;
    int  m_loss = 0;
    bit  s1 = 0;
    bit  s2 = 0;
    bit  cmp_en = 0;

    // Dwell length per state; 0 = no timed exit.
    int unsigned dwell [7] = '{PD, 0, ST, MC, TA, TD, 0};

    // Output table bits: {powerdown, mcgb, txa, txd, ready, locked_output}.
    logic [5:0] out_tbl [7] = '{6'b111100, 6'b011100, 6'b011100, 6'b011101,
                                6'b001101, 6'b000101, 6'b000011};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit q, input bit l);
        bit lk_eff;
        int nxt;
`ifdef SDI_PLL_SEQ_LOCK_SYNC_EN
        lk_eff = s2;
        if (r || m_st == 0) begin
            s1 = 0;
            s2 = 0;
        end else begin
            s2 = s1;
            s1 = l;
        end
`else
        lk_eff = l;
`endif
        if (r) begin
            m_st = 0; m_age = 0; m_to = 0; m_retry = 0; m_loss = 0;
            return;
        end
        nxt = m_st;
        if (q) begin
            nxt = 0;
        end else if (m_st >= 3 && !lk_eff) begin
            nxt = 0;
            if (m_loss < 15) m_loss++;
        end else if (m_st == 1 && !lk_eff) begin
            if (m_age + 1 == int'(TO)) begin
                nxt = 0;
                m_to = 1;
                if (m_retry < 15) m_retry++;
            end
        end else if (m_st == 1) begin
            nxt = 2;
        end else if (m_st == 2 && !lk_eff) begin
            nxt = 1;
        end else if (m_age + 1 == int'(dwell[m_st])) begin
            nxt = m_st + 1;
        end
        m_age = (nxt != m_st || q) ? 0 : m_age + 1;
        m_st  = nxt;
    endtask

    // Per-cycle comparison, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("state", 32'(state_o), 32'(m_st));
            chk("outputs", 32'({pd_o, mcgb_o, txa_o, txd_o, rdy_o, plo_o}), 32'(out_tbl[m_st]));
            chk("counters", 32'({to_o, retry_o, loss_o}),
                32'({m_to, 4'(m_retry), 4'(m_loss)}));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input bit r, input bit q, input bit l);
        rst   = r;
        req   = q;
        lk_in = l;
        @(posedge clk);
        model_step(r, q, l);
        #1;
    endtask

    // Reset, then run n cycles. Cycle c is the state observed after c non-reset edges.
    // lk_low_at inverts lock for one cycle; req is high over [req_from, req_from+req_len);
    // rst_at pulses reset for one cycle. rise returns the last cycle tx_ready rose.
    task automatic run(input int n, input bit lk_base, input int lk_low_at, input int req_from,
                       input int req_len, input int rst_at, output int rise);
        bit prev;
        rise = -1;
        tick(1, 0, lk_base);
        tick(1, 0, lk_base);
        prev = 0;
        for (int c = 0; c < n; c++) begin
            if (rdy_o && !prev) rise = c;
            prev = rdy_o;
            tick(c == rst_at, (c >= req_from) && (c < req_from + req_len),
                 (c == lk_low_at) ? ~lk_base : lk_base);
        end
    endtask

    int rise;

    initial begin
        // Reset state
        tick(1, 0, 1);
        cmp_en = 1;
        tick(1, 0, 1);
        chk("reset_state", 32'(state_o), 32'd0);
        chk("reset_pd", 32'(pd_o), 32'd1);
        chk("reset_ready", 32'(rdy_o), 32'd0);
        chk("reset_counts", 32'({to_o, retry_o, loss_o}), 32'd0);

        // Constant lock: ready after full sequence
        run(20, 1, -1, -1, 0, -1, rise);
`ifdef SDI_PLL_SEQ_LOCK_SYNC_EN
        chk("ready_cycle_sync", 32'(rise), 32'd16);
`else
        chk("ready_cycle", 32'(rise), 32'd14);
`endif
        chk("ready_state", 32'(state_o), 32'd6);

        // No lock: timeout every 24 cycles, retry saturates
        run(24, 0, -1, -1, 0, -1, rise);
        chk("first_timeout_state", 32'(state_o), 32'd0);
        chk("first_timeout_flag", 32'(to_o), 32'd1);
        chk("first_retry", 32'(retry_o), 32'd1);
        repeat (400) tick(0, 0, 0);
        chk("retry_saturated", 32'(retry_o), 32'd15);
        chk("timeout_sticky", 32'(to_o), 32'd1);

`ifndef SDI_PLL_SEQ_LOCK_SYNC_EN
        // One-cycle lock glitch in STABLE
        run(25, 1, 6, -1, 0, -1, rise);
        chk("glitch_ready_cycle", 32'(rise), 32'd17);
        chk("glitch_no_loss", 32'(loss_o), 32'd0);

        // Lock drop in READY
        run(40, 1, 20, -1, 0, -1, rise);
        chk("loss_reready_cycle", 32'(rise), 32'd35);
        chk("loss_count", 32'(loss_o), 32'd1);

        // Powerdown request during TXA
        run(40, 1, -1, 10, 10, -1, rise);
        chk("pdreq_ready_cycle", 32'(rise), 32'd34);
        chk("pdreq_counts", 32'({to_o, retry_o, loss_o}), 32'd0);

        // Reset mid-TXD after a lock loss
        run(55, 1, 20, -1, 0, 33, rise);
        chk("rst_mid_ready_cycle", 32'(rise), 32'd48);
        chk("rst_mid_loss_cleared", 32'(loss_o), 32'd0);
`endif

        cmp_en = 0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
